// File: rtl/score_scan_display.sv
// Packed-BCD frame score counter with saturation, freeze/clear control and a
// multiplexed 7-segment scanner. Optional high-score register: SCORE_HIGH_SCORE_EN.
module score_scan_display #(
  parameter int DIGITS      = 6,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  freeze,
  input  logic                  clr,
`ifdef SCORE_HIGH_SCORE_EN
  input  logic                  show_hi,
  output logic [4*DIGITS-1:0]   hi_bcd,
`endif
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     anode
);

  localparam int SW    = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(REFRESH_DIV);

  function automatic logic all_nines(input logic [SW-1:0] v);
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] != 4'd9) all_nines = 1'b0;
  endfunction

  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic carry;
    bcd_inc = v;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  endfunction

  // Active-low {a,b,c,d,e,f,g}; non-decimal codes go dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic            tick_d;
  logic [SW-1:0]   score_q;
  logic            ovf_q;
  logic            evt;

  assign evt = tick & ~tick_d & ~freeze & ~clr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_d  <= 1'b0;
      score_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      tick_d <= tick;
      if (clr) begin
        score_q <= '0;
        ovf_q   <= 1'b0;
      end else if (evt) begin
        if (all_nines(score_q)) ovf_q   <= 1'b1;
        else                    score_q <= bcd_inc(score_q);
      end
    end
  end

  assign score_bcd = score_q;
  assign overflow  = ovf_q;

  // Scan: refresh divider and digit index, independent of game control.
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [IDX_W-1:0] scan_idx, idx_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else begin
      div_cnt  <= div_nxt;
      scan_idx <= idx_nxt;
    end
  end

  always_comb begin
    div_nxt = div_cnt + 1'b1;
    idx_nxt = scan_idx;
    if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
      div_nxt = '0;
      idx_nxt = (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  logic [SW-1:0] disp;

`ifdef SCORE_HIGH_SCORE_EN
  logic          freeze_d;
  logic [SW-1:0] hi_q;

  // Latch a new best score when a collision begins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      freeze_d <= 1'b0;
      hi_q     <= '0;
    end else begin
      freeze_d <= freeze;
      if (freeze && !freeze_d && (score_q > hi_q)) hi_q <= score_q;
    end
  end

  assign hi_bcd = hi_q;
  assign disp   = show_hi ? hi_q : score_q;
`else
  assign disp = score_q;
`endif

  logic [3:0] cur;
  logic       upper_zero;

  always_comb begin
    cur        = 4'd0;
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (IDX_W'(k) == scan_idx) cur = disp[4*k +: 4];
      if ((IDX_W'(k) >= scan_idx) && (disp[4*k +: 4] != 4'd0)) upper_zero = 1'b0;
    end
    seg = seg7(cur);
    if ((BLANK_LZ != 0) && (scan_idx != '0) && upper_zero) seg = 7'b1111111;
    anode = DIGITS'(1) << scan_idx;
  end

endmodule

// File: tb/tb_score_scan_display.sv
// Self-checking bench for score_scan_display (DIGITS=4, REFRESH_DIV=4) against
// an integer-arithmetic reference model of score, overflow and scan position.
module tb_score_scan_display;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int BLANK_LZ    = 1;
  localparam int SW          = 4 * DIGITS;
  localparam int PERIOD      = DIGITS * REFRESH_DIV;
  localparam int MAXV        = 10 ** DIGITS - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic freeze = 1'b0;
  logic clr = 1'b0;
  logic [SW-1:0]     score_bcd;
  logic              overflow;
  logic [6:0]        seg;
  logic [DIGITS-1:0] anode;
`ifdef SCORE_HIGH_SCORE_EN
  logic              show_hi = 1'b0;
  logic [SW-1:0]     hi_bcd;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_scan_display #(
    .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_LZ(BLANK_LZ)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .freeze(freeze), .clr(clr),
`ifdef SCORE_HIGH_SCORE_EN
    .show_hi(show_hi), .hi_bcd(hi_bcd),
`endif
    .score_bcd(score_bcd), .overflow(overflow), .seg(seg), .anode(anode)
  );

  // Reference model: plain integers, cycle position since reset.
  int m_score = 0;
  int m_hi    = 0;
  int m_cyc   = 0;
  bit m_ovf   = 1'b0;
  bit m_tick_d = 1'b0;
  bit m_fz_d  = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_score  <= 0;
      m_hi     <= 0;
      m_cyc    <= 0;
      m_ovf    <= 1'b0;
      m_tick_d <= 1'b0;
      m_fz_d   <= 1'b0;
    end else begin
      m_tick_d <= tick;
      m_fz_d   <= freeze;
      m_cyc    <= (m_cyc + 1) % PERIOD;
      if (clr) begin
        m_score <= 0;
        m_ovf   <= 1'b0;
      end else if (tick && !m_tick_d && !freeze) begin
        if (m_score == MAXV) m_ovf <= 1'b1;
        else                 m_score <= m_score + 1;
      end
      if (freeze && !m_fz_d && (m_score > m_hi)) m_hi <= m_score;
    end
  end

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  function automatic logic [SW-1:0] to_bcd(input int v);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if ((BLANK_LZ != 0) && (idx > 0) && (v < p)) return 7'b1111111;
    return seg_tab[(v / p) % 10];
  endfunction

  task automatic drive(input logic t, input logic f, input logic c);
    tick = t;
    freeze = f;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_event();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    n_checks++;
    if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL reset_score: got %h expected 0000", score_bcd); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    n_checks++;
    if (anode !== 4'b0001) begin n_fail++; $display("FAIL reset_anode: got %b expected 0001", anode); end
    n_checks++;
    if (seg !== 7'b0000001) begin n_fail++; $display("FAIL reset_seg: got %b expected 0000001", seg); end
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_count();
    for (int p = 0; p < 3; p++) begin
      for (int h = 0; h < 3; h++) begin
        drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (score_bcd !== to_bcd(p + 1)) begin
          n_fail++;
          $display("FAIL count_pulse%0d_cyc%0d: got %h expected %h", p, h, score_bcd, to_bcd(p + 1));
        end
      end
      drive(1'b0, 1'b0, 1'b0);
    end
    n_checks++;
    if (score_bcd !== 16'h0003) begin n_fail++; $display("FAIL count_total: got %h expected 0003", score_bcd); end
  endtask

  task automatic test_rollover();
    logic [6:0] want;
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 99; i++) do_event();
    n_checks++;
    if (score_bcd !== 16'h0099) begin n_fail++; $display("FAIL preload_99: got %h expected 0099", score_bcd); end
    do_event();
    n_checks++;
    if (score_bcd !== 16'h0100) begin n_fail++; $display("FAIL carry_100: got %h expected 0100", score_bcd); end
    for (int i = 0; i < PERIOD; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      case (anode)
        4'b0100: want = 7'b1001111;
        4'b1000: want = 7'b1111111;
        default: want = 7'b0000001;
      endcase
      n_checks++;
      if (seg !== want) begin n_fail++; $display("FAIL disp_100 anode=%b: got %b expected %b", anode, seg, want); end
    end
  endtask

  task automatic test_saturate();
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < MAXV; i++) do_event();
    n_checks++;
    if (score_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_reach: got %h expected 9999", score_bcd); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_early: got %b expected 0", overflow); end
    do_event();
    n_checks++;
    if (score_bcd !== 16'h9999) begin n_fail++; $display("FAIL sat_hold: got %h expected 9999", score_bcd); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_set: got %b expected 1", overflow); end
    do_event();
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_sticky: got %b expected 1", overflow); end
    drive(1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({score_bcd, overflow} !== 17'h0) begin
      n_fail++; $display("FAIL sat_clr: got %h/%b expected 0000/0", score_bcd, overflow);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 3; i++) do_event();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (score_bcd !== 16'h0003) begin n_fail++; $display("FAIL freeze_edge%0d: got %h expected 0003", i, score_bcd); end
    end
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (score_bcd !== 16'h0003) begin n_fail++; $display("FAIL freeze_consumed: got %h expected 0003", score_bcd); end
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL tick_with_clr: got %h expected 0000", score_bcd); end
    drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (score_bcd !== 16'h0000) begin n_fail++; $display("FAIL clr_consumed: got %h expected 0000", score_bcd); end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_scan();
    logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    n_checks++;
    if (anode !== 4'b0001) begin n_fail++; $display("FAIL scan_start: got %b expected 0001", anode); end
    for (int k = 1; k <= 3 * PERIOD; k++) begin
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      n_checks++;
      if (anode !== seq[(k / REFRESH_DIV) % DIGITS]) begin
        n_fail++;
        $display("FAIL scan_step%0d: got %b expected %b", k, anode, seq[(k / REFRESH_DIV) % DIGITS]);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int sv;
    logic [6:0] want;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) != 0);
`ifdef SCORE_HIGH_SCORE_EN
      show_hi = 1'($urandom_range(0, 1));
`endif
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 255) == 0));
      sv = m_score;
`ifdef SCORE_HIGH_SCORE_EN
      if (show_hi) sv = m_hi;
      n_checks++;
      if (hi_bcd !== to_bcd(m_hi)) begin n_fail++; $display("FAIL rnd_hi cyc%0d: got %h expected %h", i, hi_bcd, to_bcd(m_hi)); end
`endif
      want = exp_seg(sv, m_cyc / REFRESH_DIV);
      n_checks++;
      if (score_bcd !== to_bcd(m_score)) begin
        n_fail++; $display("FAIL rnd_score cyc%0d: got %h expected %h", i, score_bcd, to_bcd(m_score));
      end
      n_checks++;
      if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc%0d: got %b expected %b", i, overflow, m_ovf); end
      n_checks++;
      if (anode !== 4'(1 << (m_cyc / REFRESH_DIV))) begin
        n_fail++; $display("FAIL rnd_anode cyc%0d: got %b expected %b", i, anode, 4'(1 << (m_cyc / REFRESH_DIV)));
      end
      n_checks++;
      if (seg !== want) begin n_fail++; $display("FAIL rnd_seg cyc%0d: got %b expected %b", i, seg, want); end
    end
    reset = 1'b1;
`ifdef SCORE_HIGH_SCORE_EN
    show_hi = 1'b0;
`endif
    drive(1'b0, 1'b0, 1'b0);
  endtask

`ifdef SCORE_HIGH_SCORE_EN
  task automatic test_high_score();
    logic [6:0] want;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 42; i++) do_event();
    drive(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (hi_bcd !== 16'h0042) begin n_fail++; $display("FAIL hi_capture: got %h expected 0042", hi_bcd); end
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) do_event();
    drive(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (hi_bcd !== 16'h0042) begin n_fail++; $display("FAIL hi_keep: got %h expected 0042", hi_bcd); end
    drive(1'b0, 1'b0, 1'b0);
    show_hi = 1'b1;
    for (int i = 0; i < PERIOD; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      case (anode)
        4'b0001: want = 7'b0010010;
        4'b0010: want = 7'b1001100;
        default: want = 7'b1111111;
      endcase
      n_checks++;
      if (seg !== want) begin n_fail++; $display("FAIL hi_disp anode=%b: got %b expected %b", anode, seg, want); end
    end
    show_hi = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_saturate();
    test_freeze();
    test_scan();
    test_random();
`ifdef SCORE_HIGH_SCORE_EN
    test_high_score();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_scan_display.md
Name: score_scan_display

Overview:
- Parametrised successor to the single-digit frame-rate score counter.
- Counts game score in packed BCD across DIGITS digits, on rising edges of a slow frame-rate tick.
- Freezes on collision and clears on game restart.
- Time-multiplexes all digits onto one shared 7-segment bus with one-hot anodes.
- Sits beside the VGA controller and CPU wrapper in the top level, clocked by the 100 MHz system clock.

Parameters:
- DIGITS, 6: number of BCD digits counted and scanned (1..8).
- REFRESH_DIV, 100000: system-clock cycles each digit is driven before the scan advances (>=2).
- BLANK_LZ, 1: 1 = blank leading zeros (digit 0 is never blanked); 0 = show all digits.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-low reset.
- tick, input, 1: frame-rate level signal in the clk domain; its rising edge is a score event.
- freeze, input, 1: collision_detected; while 1, score events are ignored.
- clr, input, 1: game restart; synchronous score clear.
- score_bcd, output, 4*DIGITS: packed BCD score; digit 0 = bits [3:0].
- overflow, output, 1: sticky saturation flag.
- seg, output, 7: {a,b,c,d,e,f,g} = seg[6:0], active-low.
- anode, output, DIGITS: one-hot digit enable, active-high.

Behaviour:
- Edge detect: tick_d <= tick every cycle. An event occurs in a cycle where tick=1 && tick_d=0 && freeze=0 && clr=0. The score updates at that clk edge, so latency is 1 edge from tick going high. A tick held high yields exactly one event.
- Increment is a BCD ripple:
  - digit i increments if all lower digits equal 9;
  - a digit at 9 that receives a carry becomes 0.
  - Digit values never exceed 9.
- Saturation: an event while every digit is 9 leaves the score unchanged and sets overflow=1.
- overflow stays 1 until clr or reset.
- Priority: reset > clr > freeze > event.
  - clr: score_bcd=0 and overflow=0 on the next edge. tick_d still updates.
  - freeze=1 and an edge in the same cycle: the edge is consumed (tick_d updates) and no increment occurs.
- Scan FSM, two counters:
  - div_cnt counts 0..REFRESH_DIV-1;
  - when div_cnt == REFRESH_DIV-1, it returns to 0 and scan_idx advances;
  - scan_idx wraps from DIGITS-1 to 0.
  - Scan runs independently of freeze and clr; clr does not reset the scan.
- Outputs:
  - anode = 1 << scan_idx.
  - seg = active-low decode of the digit at scan_idx (0-9 standard patterns).
  - Both are combinational from registered state. The digit shown is the current score_bcd, so an update appears in the same cycle.
- Leading-zero blanking (BLANK_LZ=1): digit k>0 shows seg=7'b1111111 if it and all higher digits are 0. anode is still asserted.
- Reset values:
  - score_bcd=0, overflow=0, tick_d=0, div_cnt=0, scan_idx=0;
  - anode = {{DIGITS-1{0}},1};
  - seg = 7'b0000001 (digit '0').
- Reset mid-scan or mid-count: all of the above return to reset values on the next edge, regardless of other inputs.

Optional Feature:
- Macro: SCORE_HIGH_SCORE_EN.
- When defined:
  - Adds input show_hi (1 bit) and output hi_bcd (4*DIGITS).
  - hi_bcd resets to 0 on reset only; clr does not affect it.
  - On the clk edge where freeze rises 0->1, hi_bcd <= score_bcd if score_bcd > hi_bcd (BCD magnitude compare).
  - While show_hi=1, the scan displays hi_bcd instead of score_bcd, with the same blanking rules.
- When undefined: no show_hi/hi_bcd ports and no hi register; the display always shows score_bcd.

Test Plan:
- DIGITS=4, REFRESH_DIV=4. Reset low for 2 cycles, then 3 tick pulses, each high 3 cycles -> score_bcd=16'h0003. Each increment lands on the first high cycle.
- Preload to 0x0099 via events, then one more event -> 0x0100. Scan shows digit2='1', digit1 and digit0 ='0', digit3 blanked (7'b1111111).
- Drive 9999 events -> 0x9999 and overflow=0. One more event -> still 0x9999, overflow=1. clr -> 0x0000, overflow=0.
- freeze=1 during 5 tick edges -> score unchanged. tick and clr rising in the same cycle -> score 0, no increment.
- Scan timing: anode sequence 0001,0010,0100,1000,0001 with each step held exactly 4 cycles. Pulsing clr does not perturb the sequence.
- With SCORE_HIGH_SCORE_EN: score 0x0042, raise freeze -> hi_bcd=0x0042. clr, score to 0x0010, freeze rise -> hi_bcd stays 0x0042. show_hi=1 displays 42.
